// File: rtl/id_exp_scheduler_if.sv
// Requester-side bundle of the Id_exp scheduler: request/operand inputs, grant pulses and result registers.
// Handshake: req[i] is a level held with stable operands until granted; rslt_valid[i]/rslt_ack[i] is valid/ready (pop when both high).
interface id_exp_scheduler_if #(
    parameter int NREQ   = 4,
    parameter int SINGLE = 32
);
    logic [NREQ-1:0]        req;
    logic [NREQ*SINGLE-1:0] T_in;
    logic [NREQ*SINGLE-1:0] Ns_in;
    logic [NREQ*SINGLE-1:0] Vd_in;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rslt_valid;
    logic [NREQ-1:0]        rslt_ack;
    logic [NREQ*SINGLE-1:0] rslt_data;

    modport master (
        output req, T_in, Ns_in, Vd_in, rslt_ack,
        input  gnt, rslt_valid, rslt_data
    );

    modport slave (
        input  req, T_in, Ns_in, Vd_in, rslt_ack,
        output gnt, rslt_valid, rslt_data
    );
endinterface

// File: rtl/id_exp_scheduler.sv
// Round-robin scheduler sharing one fixed-latency Id_exp datapath among NREQ requesters, with a tag pipe routing results back.
// Optional macro ID_EXP_SCHED_PERF_EN adds issue_cnt and max_inflight performance outputs.
module id_exp_scheduler #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 51,
    parameter int SINGLE  = 32
) (
    input  logic              clk,
    input  logic              rst,
    id_exp_scheduler_if.slave rq,
    output logic              dp_sta,
    output logic [SINGLE-1:0] dp_T,
    output logic [SINGLE-1:0] dp_Ns,
    output logic [SINGLE-1:0] dp_Vd,
    input  logic              dp_done,
    input  logic [SINGLE-1:0] dp_result,
    output logic              busy,
    output logic              tag_err
`ifdef ID_EXP_SCHED_PERF_EN
    ,
    output logic [31:0]       issue_cnt,
    output logic [3:0]        max_inflight
`endif
);
    localparam int PTR_W = $clog2(NREQ);

    logic [NREQ-1:0]        pending;
    logic [PTR_W-1:0]       ptr;
    logic [NREQ-1:0]        gnt_q;
    logic [NREQ-1:0]        rslt_valid_q;
    logic [NREQ*SINGLE-1:0] rslt_data_q;
    logic [NREQ-1:0]        tag_pipe [LATENCY];

    logic [NREQ-1:0]        elig;
    logic [NREQ-1:0]        win_oh;
    logic [PTR_W-1:0]       win_idx;
    logic                   win_found;
    logic [NREQ-1:0]        tail;
    logic [NREQ-1:0]        ack_hit;
    logic [NREQ-1:0]        capture;

    assign rq.gnt        = gnt_q;
    assign rq.rslt_valid = rslt_valid_q;
    assign rq.rslt_data  = rslt_data_q;
    assign busy          = |pending;

    // A requester stays ineligible from grant until its result is acknowledged.
    assign elig    = rq.req & ~pending;
    assign tail    = tag_pipe[LATENCY-1];
    assign ack_hit = rq.rslt_ack & rslt_valid_q;
    assign capture = dp_done ? tail : '0;

    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        for (int off = 0; off < NREQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_found && elig[idx]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(idx);
            end
        end
        if (win_found) win_oh[win_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending      <= '0;
            ptr          <= '0;
            gnt_q        <= '0;
            dp_sta       <= 1'b0;
            dp_T         <= '0;
            dp_Ns        <= '0;
            dp_Vd        <= '0;
            rslt_valid_q <= '0;
            rslt_data_q  <= '0;
            tag_err      <= 1'b0;
            for (int j = 0; j < LATENCY; j++) tag_pipe[j] <= '0;
        end else begin
            gnt_q  <= win_oh;
            dp_sta <= win_found;
            if (win_found) begin
                dp_T  <= rq.T_in[int'(win_idx)*SINGLE +: SINGLE];
                dp_Ns <= rq.Ns_in[int'(win_idx)*SINGLE +: SINGLE];
                dp_Vd <= rq.Vd_in[int'(win_idx)*SINGLE +: SINGLE];
                ptr   <= (int'(win_idx) == NREQ-1) ? '0 : win_idx + 1'b1;
            end
            pending <= (pending & ~ack_hit) | win_oh;

            // Stage 0 is fed by the registered grant so the tail lines up with dp_done.
            tag_pipe[0] <= gnt_q;
            for (int j = 1; j < LATENCY; j++) tag_pipe[j] <= tag_pipe[j-1];

            rslt_valid_q <= (rslt_valid_q & ~ack_hit) | capture;
            for (int i = 0; i < NREQ; i++) begin
                if (capture[i]) rslt_data_q[i*SINGLE +: SINGLE] <= dp_result;
            end

            if ((dp_done && tail == '0) || (!dp_done && tail != '0)) tag_err <= 1'b1;
        end
    end

`ifdef ID_EXP_SCHED_PERF_EN
    logic [3:0] inflight;

    always_comb begin
        inflight = '0;
        for (int j = 0; j < LATENCY; j++) inflight = inflight + {3'b000, |tag_pipe[j]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt    <= '0;
            max_inflight <= '0;
        end else begin
            if (dp_sta) issue_cnt <= issue_cnt + 32'd1;
            if (inflight > max_inflight) max_inflight <= inflight;
        end
    end
`endif
endmodule
